// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter: default width, opcodes and sequencer states.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 4;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational integer ALU: logic ops, add with carry-out, subtract with no-borrow flag.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum    = '0;
        result = '0;
        carry  = 1'b0;
        err    = 1'b0;
        case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_SUB: begin
                result = a - b;
                carry  = (a >= b);
            end
            default: err = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of alu_core (IDLE -> EXEC -> RESP).
// Optional per-requester grant counters are enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
`ifdef ALU_ARB_STATS_EN
    output logic [7:0]       grant_cnt0,
    output logic [7:0]       grant_cnt1,
`endif
    output logic             rsp_err
);

    state_e           state_q, state_d;
    logic             last_grant_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             id_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q, zero_q, err_q;

    logic             grant_en, grant_id;
    logic [2:0]       grant_op;
    logic [WIDTH-1:0] grant_a, grant_b;
    logic [WIDTH-1:0] core_result;
    logic             core_carry, core_zero, core_err;

    // Contention goes to whoever was not served last; rst_n gating keeps ready low in reset.
    always_comb begin
        grant_id   = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        grant_en   = rst_n && (state_q == S_IDLE) && (req0_valid || req1_valid);
        req0_ready = grant_en && !grant_id;
        req1_ready = grant_en && grant_id;
        grant_op   = grant_id ? req1_op : req0_op;
        grant_a    = grant_id ? req1_a  : req0_a;
        grant_b    = grant_id ? req1_b  : req0_b;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_en) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (core_result),
        .carry  (core_carry),
        .zero   (core_zero),
        .err    (core_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            result_q     <= '0;
            carry_q      <= 1'b0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_en) begin
                op_q <= grant_op;
                a_q  <= grant_a;
                b_q  <= grant_b;
                id_q <= grant_id;
            end
            if (state_q == S_EXEC) begin
                result_q <= core_result;
                carry_q  <= core_carry;
                zero_q   <= core_zero;
                err_q    <= core_err;
            end
            if (state_q == S_RESP && rsp_ready) begin
                last_grant_q <= id_q;
            end
        end
    end

    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_carry  = carry_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;

`ifdef ALU_ARB_STATS_EN
    logic [7:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (req0_ready && cnt0_q != 8'hff) cnt0_q <= cnt0_q + 8'd1;
            if (req1_ready && cnt1_q != 8'hff) cnt1_q <= cnt1_q + 8'd1;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expectations queued at grant, compared at response.
`timescale 1ns/1ps
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic         id;
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         e;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero, rsp_err;
    logic [W-1:0] rsp_result;
`ifdef ALU_ARB_STATS_EN
    logic [7:0]   grant_cnt0, grant_cnt1;
`endif

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    alu_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
`ifdef ALU_ARB_STATS_EN
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
`endif
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    // Reference: subtract as a + ~b + 1 so the carry is the no-borrow bit.
    function automatic exp_t model(input logic id, input logic [2:0] op,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t     r;
        logic [W:0] s;
        r = '0;
        r.id = id;
        case (op)
            3'b000: r.res = a & b;
            3'b001: r.res = a | b;
            3'b010: r.res = a ^ b;
            3'b011: r.res = ~a;
            3'b100: begin s = {1'b0, a} + {1'b0, b}; r.res = s[W-1:0]; r.c = s[W]; end
            3'b101: begin s = {1'b0, a} + {1'b0, ~b} + 1; r.res = s[W-1:0]; r.c = s[W]; end
            default: begin r.res = '0; r.e = 1'b1; end
        endcase
        r.z = (r.res == '0);
        return r;
    endfunction

    function automatic exp_t rsp_word();
        return {rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_err};
    endfunction

    function automatic exp_t sb_pop(output bit have);
        have = (sb.size() != 0);
        if (have) return sb.pop_front();
        return '0;
    endfunction

    always @(negedge clk) begin
        if (rst_n && req0_ready) sb.push_back(model(1'b0, req0_op, req0_a, req0_b));
        if (rst_n && req1_ready) sb.push_back(model(1'b1, req1_op, req1_a, req1_b));
    end

    task automatic drive_req(input logic id, input logic [2:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk); #1;
        if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    endtask

    task automatic wait_grant(input logic id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({req0_ready, req1_ready, rsp_valid, rsp_word()} !== '0)
            $display("FAIL reset_held: outputs=%h want 0", {req0_ready, req1_ready, rsp_valid, rsp_word()});
        else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({req0_ready, req1_ready, rsp_valid, rsp_word()} !== '0)
            $display("FAIL reset_released: outputs=%h want 0", {req0_ready, req1_ready, rsp_valid, rsp_word()});
        else n_pass++;
        sb.delete();
    endtask

    task automatic test_basic_or();
        exp_t e; bit have;
        drive_req(1'b0, OP_OR, 4'b1010, 4'b1100);
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10)
            $display("FAIL or_grant: ready=%b want 10", {req0_ready, req1_ready});
        else n_pass++;
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, req0_ready, req1_ready} !== 3'b000)
            $display("FAIL or_exec_cycle: valid,ready=%b want 000", {rsp_valid, req0_ready, req1_ready});
        else n_pass++;
        @(negedge clk);
        e = sb_pop(have);
        n_checks++;
        if (!rsp_valid || !have || rsp_word() !== e || e !== exp_t'({1'b0, 4'b1110, 3'b000}))
            $display("FAIL or_rsp: valid=%b got %h want %h", rsp_valid, rsp_word(), e);
        else n_pass++;
    endtask

    task automatic test_add_sub();
        exp_t e; bit have, ok, okr;
        drive_req(1'b1, OP_ADD, 4'b1111, 4'b0001);
        wait_grant(1'b1, ok);
        wait_rsp(okr);
        e = sb_pop(have);
        n_checks++;
        if (!ok || !okr || !have || rsp_word() !== e || e !== exp_t'({1'b1, 4'b0000, 3'b110}))
            $display("FAIL add_wrap: got %h want %h (grant=%b rsp=%b)", rsp_word(), e, ok, okr);
        else n_pass++;
        drive_req(1'b1, OP_SUB, 4'b0011, 4'b0101);
        wait_grant(1'b1, ok);
        wait_rsp(okr);
        e = sb_pop(have);
        n_checks++;
        if (!ok || !okr || !have || rsp_word() !== e || e !== exp_t'({1'b1, 4'b1110, 3'b000}))
            $display("FAIL sub_borrow: got %h want %h (grant=%b rsp=%b)", rsp_word(), e, ok, okr);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e; bit have, okr;
        int grants = 0;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = OP_XOR; req0_a = 4'b0110; req0_b = 4'b0011;
        req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 4'b0101; req1_b = 4'b0110;
        for (int cyc = 0; cyc < 40 && grants < 6; cyc++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                n_checks++;
                if ({req0_ready, req1_ready} !== ((grants % 2) ? 2'b01 : 2'b10))
                    $display("FAIL b2b_grant%0d: ready=%b want %b", grants,
                             {req0_ready, req1_ready}, (grants % 2) ? 2'b01 : 2'b10);
                else n_pass++;
                grants++;
            end
            if (rsp_valid) begin
                e = sb_pop(have);
                n_checks++;
                if (!have || rsp_word() !== e)
                    $display("FAIL b2b_rsp: got %h want %h", rsp_word(), e);
                else n_pass++;
            end
        end
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        n_checks++;
        if (grants != 6) $display("FAIL b2b_count: grants=%0d want 6", grants);
        else n_pass++;
        wait_rsp(okr);
        e = sb_pop(have);
        n_checks++;
        if (!okr || !have || rsp_word() !== e)
            $display("FAIL b2b_last_rsp: got %h want %h (rsp=%b)", rsp_word(), e, okr);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        exp_t e; bit have, ok, okr;
        drive_req(1'b0, OP_AND, 4'b1101, 4'b0111);
        rsp_ready = 1'b0;
        wait_grant(1'b0, ok);
        req1_valid = 1'b1; req1_op = OP_NOT; req1_a = 4'b1111; req1_b = 4'b0101;
        wait_rsp(okr);
        e = sb_pop(have);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (!ok || !okr || !have || !rsp_valid || rsp_word() !== e || req0_ready || req1_ready)
                $display("FAIL hold_cycle%0d: valid=%b got %h want %h ready=%b", i, rsp_valid,
                         rsp_word(), e, {req0_ready, req1_ready});
            else n_pass++;
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (!rsp_valid || rsp_word() !== e || req1_ready)
            $display("FAIL handshake_cycle: valid=%b got %h want %h req1_ready=%b",
                     rsp_valid, rsp_word(), e, req1_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b01)
            $display("FAIL grant_after_idle: ready=%b want 01", {req0_ready, req1_ready});
        else n_pass++;
        @(posedge clk); #1 req1_valid = 1'b0;
        wait_rsp(okr);
        e = sb_pop(have);
        n_checks++;
        if (!okr || !have || rsp_word() !== e || e !== exp_t'({1'b1, 4'b0000, 3'b010}))
            $display("FAIL not_rsp: got %h want %h", rsp_word(), e);
        else n_pass++;
    endtask

    task automatic test_illegal();
        exp_t e; bit have, ok, okr;
        drive_req(1'b0, 3'b111, 4'b1011, 4'b0110);
        wait_grant(1'b0, ok);
        wait_rsp(okr);
        e = sb_pop(have);
        n_checks++;
        if (!ok || !okr || !have || rsp_word() !== e)
            $display("FAIL illegal_rsp: got %h want %h", rsp_word(), e);
        else n_pass++;
        n_checks++;
        if ({rsp_err, rsp_result, rsp_zero, rsp_carry} !== 7'b1_0000_1_0)
            $display("FAIL illegal_flags: err,res,zero,carry=%b want 1000010",
                     {rsp_err, rsp_result, rsp_zero, rsp_carry});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        exp_t e; bit have, ok, okr, seen;
        drive_req(1'b1, OP_ADD, 4'b0111, 4'b0001);
        wait_grant(1'b1, ok);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (!ok || {req0_ready, req1_ready, rsp_valid, rsp_word()} !== '0)
            $display("FAIL async_reset: outputs=%h want 0 (grant=%b)",
                     {req0_ready, req1_ready, rsp_valid, rsp_word()}, ok);
        else n_pass++;
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
        n_checks++;
        if (seen) $display("FAIL dropped_op: rsp_valid=1 want 0");
        else n_pass++;
        drive_req(1'b0, OP_XOR, 4'b1001, 4'b1001);
        req1_valid = 1'b1; req1_op = OP_OR; req1_a = 4'b0001; req1_b = 4'b0100;
        @(negedge clk);
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10)
            $display("FAIL post_reset_priority: ready=%b want 10", {req0_ready, req1_ready});
        else n_pass++;
        @(posedge clk); #1 req0_valid = 1'b0;
        wait_rsp(okr);
        e = sb_pop(have);
        n_checks++;
        if (!okr || !have || rsp_word() !== e || e !== exp_t'({1'b0, 4'b0000, 3'b010}))
            $display("FAIL post_reset_rsp0: got %h want %h", rsp_word(), e);
        else n_pass++;
        wait_grant(1'b1, ok);
        wait_rsp(okr);
        e = sb_pop(have);
        n_checks++;
        if (!ok || !okr || !have || rsp_word() !== e)
            $display("FAIL post_reset_rsp1: got %h want %h (grant=%b)", rsp_word(), e, ok);
        else n_pass++;
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic test_stats();
        int grants = 0;
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        sb.delete();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = OP_AND; req0_a = 4'b1111; req0_b = 4'b0101;
        for (int cyc = 0; cyc < 2000 && grants < 300; cyc++) begin
            @(negedge clk);
            if (req0_ready) grants++;
            if (rsp_valid && sb.size() != 0) void'(sb.pop_front());
        end
        @(posedge clk); #1 req0_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (grants != 300 || grant_cnt0 !== 8'd255 || grant_cnt1 !== 8'd0)
            $display("FAIL stats_saturate: grants=%0d cnt0=%0d cnt1=%0d want 300/255/0",
                     grants, grant_cnt0, grant_cnt1);
        else n_pass++;
        sb.delete();
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_or();
        test_add_sub();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_reset_mid();
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
